// File: rtl/axioma_pkg.sv
// Shared definitions for the AxiomaCore-328 front end: PC width default,
// fetch FSM encoding and the NOP instruction word.
package axioma_pkg;

  localparam int AXIOMA_PC_WIDTH = 14;
  localparam logic [15:0] AXIOMA_NOP = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/axioma_fetch_fifo.sv
// Prefetch FIFO between the Flash port and the decoder. Head word is visible
// combinationally; flush beats push and pop. DEPTH must be a power of two >= 2.
module axioma_fetch_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    rptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;
  assign rdata = mem_reg[rptr_reg];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (do_push && (wptr_reg == AW'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + AW'(1);
      if (do_pop)  rptr_reg <= rptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/axioma_fetch_unit.sv
// AxiomaCore-328 instruction fetch: PC, Flash req/ack FSM, prefetch FIFO and redirect.
// Optional AXIOMA_FETCH_PERF_EN adds saturating perf_fetched/perf_flushed counters.
module axioma_fetch_unit
  import axioma_pkg::*;
#(
  parameter int                  PC_WIDTH     = AXIOMA_PC_WIDTH,
  parameter int                  FIFO_DEPTH   = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                flash_req,
  output logic [PC_WIDTH-1:0] flash_addr,
  input  logic                flash_ack,
  input  logic [15:0]         flash_rdata,
  output logic [15:0]         instruction,
  output logic [PC_WIDTH-1:0] instruction_pc,
  output logic                instruction_valid,
  input  logic                instruction_ready,
  input  logic                redirect_en,
  input  logic [PC_WIDTH-1:0] redirect_pc
`ifdef AXIOMA_FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushed
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 16 + PC_WIDTH;

  fetch_state_t        state_reg, state_next;
  logic [PC_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [PC_WIDTH-1:0] flash_addr_reg;
  logic                discard_reg, discard_next;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count, occ_after;
  logic [EW-1:0]       fifo_wdata, fifo_rdata;
  logic                resp_dropped;

  assign flash_req  = (state_reg == S_REQ) && !reset;
  assign flash_addr = flash_addr_reg;

  assign instruction_valid = !fifo_empty && !redirect_en;
  assign fifo_pop          = instruction_valid && instruction_ready;
  assign instruction       = fifo_empty ? AXIOMA_NOP : fifo_rdata[PC_WIDTH +: 16];
  assign instruction_pc    = fifo_empty ? '0 : fifo_rdata[PC_WIDTH-1:0];

  assign fifo_wdata   = {flash_rdata, flash_addr_reg};
  assign resp_dropped = (state_reg == S_REQ) && flash_ack && (discard_reg || redirect_en);
  assign occ_after    = fifo_count + CW'(1) - CW'(fifo_pop);

  axioma_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .flush (redirect_en),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    discard_next  = discard_reg;
    fifo_push     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        state_next = S_REQ;
        if (redirect_en) fetch_pc_next = redirect_pc;
      end
      S_REQ: begin
        if (flash_ack) begin
          discard_next = 1'b0;
          if (resp_dropped) begin
            // fetch_pc_reg already holds the pending target when discarding
            fetch_pc_next = redirect_en ? redirect_pc : fetch_pc_reg;
          end else begin
            fifo_push     = 1'b1;
            fetch_pc_next = flash_addr_reg + PC_WIDTH'(1);
            if (occ_after == CW'(FIFO_DEPTH)) state_next = S_HOLD;
          end
        end else if (redirect_en) begin
          discard_next  = 1'b1;
          fetch_pc_next = redirect_pc;
        end
      end
      S_HOLD: begin
        if (redirect_en) begin
          fetch_pc_next = redirect_pc;
          state_next    = S_REQ;
        end else if (fifo_pop || !fifo_full) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      fetch_pc_reg   <= RESET_VECTOR;
      flash_addr_reg <= RESET_VECTOR;
      discard_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      discard_reg  <= discard_next;
      // Address stays frozen while a request is waiting for its ack.
      if (!((state_reg == S_REQ) && !flash_ack)) begin
        flash_addr_reg <= fetch_pc_next;
      end
    end
  end

`ifdef AXIOMA_FETCH_PERF_EN
  logic [31:0]   perf_fetched_reg, perf_flushed_reg;
  logic [32:0]   fetched_sum, flushed_sum;
  logic [CW-1:0] flushed_entries;

  always_comb begin
    flushed_entries = redirect_en ? fifo_count : '0;
    fetched_sum     = {1'b0, perf_fetched_reg} + 33'(fifo_push);
    flushed_sum     = {1'b0, perf_flushed_reg} + 33'(flushed_entries) + 33'(resp_dropped);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_reg <= '0;
      perf_flushed_reg <= '0;
    end else begin
      perf_fetched_reg <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      perf_flushed_reg <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_flushed = perf_flushed_reg;
`endif

endmodule

// File: tb/tb_axioma_fetch_unit.sv
// Bench for axioma_fetch_unit: Flash responder with variable latency, directed
// scenarios, then random ready/redirect traffic checked against the expected PC stream.
module tb_axioma_fetch_unit;
  import axioma_pkg::*;

  localparam int PCW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, flash_req, flash_ack, instruction_valid, instruction_ready, redirect_en;
  logic [PCW-1:0] flash_addr, instruction_pc, redirect_pc;
  logic [15:0]    flash_rdata, instruction;
`ifdef AXIOMA_FETCH_PERF_EN
  logic [31:0]    perf_fetched, perf_flushed;
  logic [31:0]    perf_before;
`endif

  axioma_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .flash_req         (flash_req),
    .flash_addr        (flash_addr),
    .flash_ack         (flash_ack),
    .flash_rdata       (flash_rdata),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready),
    .redirect_en       (redirect_en),
    .redirect_pc       (redirect_pc)
`ifdef AXIOMA_FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_flushed      (perf_flushed)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Flash contents: any fixed function of the address; word 0 is 16'hE0F5.
  function automatic logic [15:0] mem_word(input logic [PCW-1:0] a);
    logic [15:0] x;
    x = {2'b00, a};
    return 16'hE0F5 ^ (x * 16'h2F1B);
  endfunction

  // Stimulus controls.
  logic           rst_v = 1'b1, redir_v = 1'b0, ready_v = 1'b0, stray_ack = 1'b0;
  logic [PCW-1:0] redir_pc_v = '0;
  int             fl_lat = 1;
  bit             rand_lat = 1'b0;

  // Flash responder state.
  bit             fl_busy = 1'b0;
  logic [PCW-1:0] fl_addr = '0;
  int             fl_wait = 0;

  // Expected stream: next PC the decoder must see.
  logic [PCW-1:0] exp_pc = '0;
  int             stall = 0, max_stall = 0, pops = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    reset             = rst_v;
    redirect_en       = redir_v;
    redirect_pc       = redir_pc_v;
    instruction_ready = ready_v;
    flash_ack         = 1'b0;
    flash_rdata       = 16'h0000;
    #1;
    if (stray_ack) begin
      flash_ack   = 1'b1;
      flash_rdata = 16'hDEAD;
      stray_ack   = 1'b0;
    end else if (flash_req) begin
      if (!fl_busy) begin
        fl_busy = 1'b1;
        fl_addr = flash_addr;
        fl_wait = rand_lat ? int'($urandom_range(1, 3)) : fl_lat;
      end else begin
        chk("addr_stable", 32'(flash_addr), 32'(fl_addr));
        fl_wait--;
        if (fl_wait == 0) begin
          flash_ack   = 1'b1;
          flash_rdata = mem_word(fl_addr);
          fl_busy     = 1'b0;
        end
      end
    end else begin
      if (fl_busy && !reset) chk("req_held", 32'(flash_req), 32'd1);
      fl_busy = 1'b0;
    end
    @(negedge clk);
    if (reset) begin
      exp_pc = '0;
      stall  = 0;
    end else if (redirect_en) begin
      chk("redir_valid", 32'(instruction_valid), 32'd0);
      exp_pc = redirect_pc;
      stall  = 0;
    end else if (instruction_valid && instruction_ready) begin
      $display("pop pc=%h instr=%h", instruction_pc, instruction);
      chk("pop_pc", 32'(instruction_pc), 32'(exp_pc));
      chk("pop_word", 32'(instruction), 32'(mem_word(exp_pc)));
      exp_pc++;
      pops++;
      stall = 0;
    end else if (instruction_ready) begin
      stall++;
      if (stall > max_stall) max_stall = stall;
    end else begin
      stall = 0;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instruction_valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(instruction_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0; instruction_ready = 1'b0;
    flash_ack = 1'b0; flash_rdata = 16'h0000;

    // 1: reset release, 1-cycle Flash
    rst_v = 1'b1; tick(); tick(); rst_v = 1'b0;
    tick();
    chk("t1_rst_req", 32'(flash_req), 32'd0);
    chk("t1_rst_addr", 32'(flash_addr), 32'd0);
    chk("t1_rst_valid", 32'(instruction_valid), 32'd0);
    chk("t1_rst_instr", 32'(instruction), 32'h0000);
    chk("t1_rst_pc", 32'(instruction_pc), 32'd0);
`ifdef AXIOMA_FETCH_PERF_EN
    chk("t1_rst_perf_f", perf_fetched, 32'd0);
    chk("t1_rst_perf_x", perf_flushed, 32'd0);
`endif
    tick();
    chk("t1_req", 32'(flash_req), 32'd1);
    chk("t1_addr", 32'(flash_addr), 32'd0);
    tick();
    chk("t1_ack_cycle", 32'(flash_ack), 32'd1);
    chk("t1_not_yet_valid", 32'(instruction_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(instruction_valid), 32'd1);
    chk("t1_instr", 32'(instruction), 32'hE0F5);
    chk("t1_pc", 32'(instruction_pc), 32'd0);

    // 2: decoder stalled, FIFO fills, then drains in order
    repeat (4) tick();
    chk("t2_hold_req", 32'(flash_req), 32'd0);
    chk("t2_head_pc", 32'(instruction_pc), 32'd0);
    ready_v = 1'b1;
    tick();
    chk("t2_pop0_valid", 32'(instruction_valid), 32'd1);
    chk("t2_pop0_pc", 32'(instruction_pc), 32'd0);
    tick();
    chk("t2_pop1_pc", 32'(instruction_pc), 32'd1);
    chk("t2_resume_req", 32'(flash_req), 32'd1);
    chk("t2_resume_addr", 32'(flash_addr), 32'd2);
    tick();
    chk("t2_only_two", 32'(instruction_valid), 32'd0);

    // 3: redirect while the request to 5 waits on a 3-cycle ack
    fl_lat = 3;
    redir_v = 1'b1; redir_pc_v = 14'd5; tick(); redir_v = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!(flash_req && flash_addr == 14'd5) && n < 20);
    chk("t3_req5", 32'(flash_req && flash_addr == 14'd5), 32'd1);
`ifdef AXIOMA_FETCH_PERF_EN
    perf_before = perf_flushed;
`endif
    redir_v = 1'b1; redir_pc_v = 14'h0100; tick(); redir_v = 1'b0;
    tick();
    chk("t3_req_kept", 32'(flash_req), 32'd1);
    tick();
    chk("t3_ack_cycle", 32'(flash_ack), 32'd1);
    chk("t3_addr_kept", 32'(flash_addr), 32'd5);
    tick();
    chk("t3_new_req", 32'(flash_req), 32'd1);
    chk("t3_new_addr", 32'(flash_addr), 32'h100);
`ifdef AXIOMA_FETCH_PERF_EN
    chk("t3_perf_flushed", 32'(perf_flushed > perf_before), 32'd1);
`endif
    wait_valid("t3_valid_timeout");
    chk("t3_first_pc", 32'(instruction_pc), 32'h100);

    // 4: redirect coincident with ack while decoder is ready
    ready_v = 1'b0; fl_lat = 2;
    redir_v = 1'b1; redir_pc_v = 14'h0180; tick(); redir_v = 1'b0;
    wait_valid("t4_valid_timeout");
    chk("t4_head_pc", 32'(instruction_pc), 32'h180);
    tick();
`ifdef AXIOMA_FETCH_PERF_EN
    perf_before = perf_flushed;
`endif
    redir_v = 1'b1; redir_pc_v = 14'h0200; ready_v = 1'b1; tick();
    chk("t4_coincide", 32'(flash_ack), 32'd1);
    chk("t4_valid_forced", 32'(instruction_valid), 32'd0);
    redir_v = 1'b0; ready_v = 1'b0; tick();
    chk("t4_empty", 32'(instruction_valid), 32'd0);
    chk("t4_req", 32'(flash_req), 32'd1);
    chk("t4_addr", 32'(flash_addr), 32'h200);
`ifdef AXIOMA_FETCH_PERF_EN
    chk("t4_perf_flushed", perf_flushed - perf_before, 32'd2);
`endif

    // 5: PC wraps at the top of Flash
    rand_lat = 1'b1; ready_v = 1'b1;
    redir_v = 1'b1; redir_pc_v = 14'h3FFF; tick(); redir_v = 1'b0;
    wait_valid("t5_valid_timeout");
    chk("t5_pc_top", 32'(instruction_pc), 32'h3FFF);
    tick();
    wait_valid("t5_wrap_timeout");
    chk("t5_pc_wrap", 32'(instruction_pc), 32'h0000);

    // 6: reset with a request outstanding, stale ack afterwards
    rand_lat = 1'b0; fl_lat = 3;
    n = 0;
    do begin tick(); n++; end while (!flash_req && n < 20);
    chk("t6_inflight", 32'(flash_req), 32'd1);
    rst_v = 1'b1; tick();
    chk("t6_req_drop", 32'(flash_req), 32'd0);
    rst_v = 1'b0; stray_ack = 1'b1; tick();
    chk("t6_idle_req", 32'(flash_req), 32'd0);
    chk("t6_idle_valid", 32'(instruction_valid), 32'd0);
`ifdef AXIOMA_FETCH_PERF_EN
    chk("t6_perf_f", perf_fetched, 32'd0);
    chk("t6_perf_x", perf_flushed, 32'd0);
`endif
    tick();
    chk("t6_req", 32'(flash_req), 32'd1);
    chk("t6_addr", 32'(flash_addr), 32'd0);
    wait_valid("t6_valid_timeout");
    chk("t6_pc", 32'(instruction_pc), 32'd0);
    chk("t6_instr", 32'(instruction), 32'hE0F5);

    // Random traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ready_v = ($urandom_range(0, 9) < 7);
      redir_v = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) redir_pc_v = 14'h3FFC + PCW'($urandom_range(0, 3));
      else                           redir_pc_v = PCW'($urandom);
      tick();
    end
    redir_v = 1'b0;
    ready_v = 1'b1;
    repeat (20) tick();
    chk("liveness", 32'(max_stall <= 10), 32'd1);
    chk("throughput", 32'(pops > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
